// File: rtl/imem_responder.sv
// imem_responder
//
// Instruction-memory responder for the RV64 fetch stage. A fetch PC is taken
// over a valid/ready request channel, looked up in a word-addressed RAM after
// a fixed LATENCY, and the 32-bit instruction plus an error flag come back
// over a valid/ready response channel. A side-band load port writes words into
// the RAM at any time, including while fetches are running.
//
// Parameters:
//   DEPTH_WORDS  RAM size in 32-bit words (power of two, >= 4)
//   BASE_ADDR    byte address of word 0 (word aligned)
//   LATENCY      acceptance-to-response cycles, 1..4
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous reset, active low (0 = reset)
//   req_valid  fetch request present
//   req_ready  responder can take a request (registered credit state only)
//   req_addr   fetch byte address (PC)
//   rsp_valid  response present
//   rsp_ready  core takes the response this cycle
//   rsp_inst   fetched instruction, 32'h0 on error
//   rsp_err    misaligned or out-of-range fetch
//   ld_en      preload write strobe
//   ld_addr    preload byte address, same mapping as req_addr
//   ld_data    preload word

module imem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_inst,
  output logic        rsp_err,
  input  logic        ld_en,
  input  logic [63:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int AW   = $clog2(DEPTH_WORDS);
  localparam int LAST = LATENCY - 1;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [63:0]   fetch_off;
  logic [63:0]   load_off;
  logic          fetch_err;
  logic          load_ok;
  logic [AW-1:0] fetch_idx;
  logic [AW-1:0] load_idx;

  logic          accept;
  logic          rsp_fire;
  logic [1:0]    outstanding;

  logic          pipe_vld  [LATENCY];
  logic          pipe_err  [LATENCY];
  logic [31:0]   pipe_data [LATENCY];

  logic [31:0]   fifo_data [2];
  logic          fifo_err  [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    fifo_count;
  logic          fifo_push;

  // Address decode works on the offset from BASE_ADDR. Any set bit above the
  // word index means the address is past the end of the RAM, and the explicit
  // below-base compare stops a wrapped subtraction from aliasing into range.
  assign fetch_off = req_addr - BASE_ADDR;
  assign fetch_idx = fetch_off[AW+1:2];
  assign fetch_err = (fetch_off[1:0] != 2'b00) ||
                     (req_addr < BASE_ADDR) ||
                     (fetch_off[63:AW+2] != '0);

  assign load_off  = ld_addr - BASE_ADDR;
  assign load_idx  = load_off[AW+1:2];
  assign load_ok   = (load_off[1:0] == 2'b00) &&
                     (ld_addr >= BASE_ADDR) &&
                     (load_off[63:AW+2] == '0);

  // The credit limit of two covers both the latency pipeline and the response
  // FIFO, so the FIFO can never overflow and the pipeline never has to stall.
  assign req_ready = (outstanding < 2'd2);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (fifo_count != 2'd0);
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign rsp_inst  = fifo_data[rd_ptr];
  assign rsp_err   = fifo_err[rd_ptr];
  assign fifo_push = pipe_vld[LAST];

  // Outstanding-request counter; an accept and a response handshake in the
  // same cycle cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= 2'd0;
    end else begin
      case ({accept, rsp_fire})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Pipeline valid/err tags. Clearing these on reset is what discards any
  // in-flight fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        pipe_vld[k] <= 1'b0;
        pipe_err[k] <= 1'b0;
      end
    end else begin
      pipe_vld[0] <= accept;
      pipe_err[0] <= fetch_err;
      for (int k = 1; k < LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_err[k] <= pipe_err[k-1];
      end
    end
  end

  // RAM and pipeline data carry no reset so the program image survives it.
  // The fetch read samples mem before this edge's load write lands, giving
  // old data when a load and a fetch hit the same word together.
  always_ff @(posedge clk) begin
    if (ld_en && load_ok) begin
      mem[load_idx] <= ld_data;
    end
    if (accept) begin
      pipe_data[0] <= fetch_err ? 32'h0 : mem[fetch_idx];
    end
    for (int k = 1; k < LATENCY; k++) begin
      pipe_data[k] <= pipe_data[k-1];
    end
  end

  // Two-entry in-order response FIFO. Entries are cleared on reset so the
  // response outputs read zero while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_data[0] <= 32'h0;
      fifo_data[1] <= 32'h0;
      fifo_err[0]  <= 1'b0;
      fifo_err[1]  <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_count   <= 2'd0;
    end else begin
      if (fifo_push) begin
        fifo_data[wr_ptr] <= pipe_data[LAST];
        fifo_err[wr_ptr]  <= pipe_err[LAST];
        wr_ptr            <= ~wr_ptr;
      end
      if (rsp_fire) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({fifo_push, rsp_fire})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder
//
// Self-checking bench for imem_responder. Two instances share all inputs: one
// with LATENCY = 1 and one with LATENCY = 3; use3 selects which one is
// observed. The reference model is a transaction queue: each accepted fetch is
// pushed with its expected data, error flag and the cycle it becomes visible;
// req_ready is "fewer than two queued", rsp_valid is "head is due".

module tb_imem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        rsp_ready;
  logic        ld_en;
  logic [63:0] ld_addr;
  logic [31:0] ld_data;

  logic        r1_ready, r1_valid, r1_err;
  logic [31:0] r1_inst;
  logic        r3_ready, r3_valid, r3_err;
  logic [31:0] r3_inst;

  logic        use3;
  logic        obs_ready, obs_valid, obs_err;
  logic [31:0] obs_inst;

  int          checks;
  int          errors;
  int          cyc;
  int          lat;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] q_inst [$];
  logic        q_err  [$];
  int          q_due  [$];

  logic [63:0] fl_addr [$];
  logic [31:0] fl_inst [$];
  logic        fl_err  [$];

  assign obs_ready = use3 ? r3_ready : r1_ready;
  assign obs_valid = use3 ? r3_valid : r1_valid;
  assign obs_err   = use3 ? r3_err   : r1_err;
  assign obs_inst  = use3 ? r3_inst  : r1_inst;

  imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(r1_ready), .req_addr(req_addr),
    .rsp_valid(r1_valid), .rsp_ready(rsp_ready), .rsp_inst(r1_inst), .rsp_err(r1_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(r3_ready), .req_addr(req_addr),
    .rsp_valid(r3_valid), .rsp_ready(rsp_ready), .rsp_inst(r3_inst), .rsp_err(r3_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit addr_ok(input logic [63:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && (a < BASE + 64'(4 * DEPTH));
  endfunction

  function automatic int word_of(input logic [63:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic bit m_ready();
    return q_inst.size() < 2;
  endfunction

  function automatic bit m_valid();
    if (q_inst.size() == 0) return 1'b0;
    return cyc >= q_due[0];
  endfunction

  task automatic model_clear();
    q_inst.delete();
    q_err.delete();
    q_due.delete();
  endtask

  // Advance one clock: the model decides acceptance/handshake from the inputs
  // held before the edge, then updates at the edge. Returns at the negedge.
  task automatic tick();
    bit          acc, hs, ok;
    logic [31:0] rd;
    acc = (rst === 1'b1) && (req_valid === 1'b1) && m_ready();
    hs  = (rst === 1'b1) && (rsp_ready === 1'b1) && m_valid();
    ok  = addr_ok(req_addr);
    rd  = ok ? mem_m[word_of(req_addr)] : 32'h0;
    @(posedge clk);
    cyc++;
    if (hs) begin
      void'(q_inst.pop_front());
      void'(q_err.pop_front());
      void'(q_due.pop_front());
    end
    if (acc) begin
      q_inst.push_back(rd);
      q_err.push_back(!ok);
      q_due.push_back(cyc + lat);
    end
    if (ld_en === 1'b1 && addr_ok(ld_addr)) mem_m[word_of(ld_addr)] = ld_data;
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    ld_en     = 1'b0;
    rst       = 1'b0;
    model_clear();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic preload();
    for (int w = 0; w < 17; w++) begin
      int word;
      word    = (w == 16) ? DEPTH - 1 : w;
      ld_en   = 1'b1;
      ld_addr = BASE + 64'(4 * word);
      case (word)
        0:       ld_data = 32'h0000_0093;
        1:       ld_data = 32'h0010_0113;
        2:       ld_data = 32'h0020_0193;
        3:       ld_data = 32'h0030_0213;
        5:       ld_data = 32'h0000_0013;
        default: ld_data = $urandom;
      endcase
      tick();
    end
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; ld_en = 1'b0;
    req_addr = '0; ld_addr = '0; ld_data = '0;
    use3 = 1'b0; lat = 1; cyc = 0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (r1_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset req_ready: got %b, expected 1", r1_ready); end
    checks++;
    if (r1_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset rsp_valid: got %b, expected 0", r1_valid); end
    checks++;
    if (r1_err !== 1'b0) begin errors++; $display("[TB] FAIL reset rsp_err: got %b, expected 0", r1_err); end
    checks++;
    if (r1_inst !== 32'h0) begin errors++; $display("[TB] FAIL reset rsp_inst: got %h, expected 0", r1_inst); end
    checks++;
    if (r3_valid !== 1'b0 || r3_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset lat3 valid/ready: got %b/%b, expected 0/1", r3_valid, r3_ready);
    end
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (r1_ready !== 1'b1 || r1_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL post-reset ready/valid: got %b/%b, expected 1/0", r1_ready, r1_valid);
    end
  endtask

  // Sends the addresses in fl_addr with rsp_ready high and compares each DUT
  // response, in order, with fl_inst/fl_err; the model is checked every cycle.
  task automatic test_fetch_list(input string tag);
    int sent, got, budget;
    sent = 0; got = 0; budget = 0;
    rsp_ready = 1'b1;
    ld_en     = 1'b0;
    while (got < fl_addr.size() && budget < 40) begin
      req_valid = (sent < fl_addr.size());
      if (sent < fl_addr.size()) req_addr = fl_addr[sent];
      checks++;
      if (obs_ready !== m_ready()) begin
        errors++; $display("[TB] FAIL %s req_ready: got %b, expected %b (cycle %0d)", tag, obs_ready, m_ready(), cyc);
      end
      checks++;
      if (obs_valid !== m_valid()) begin
        errors++; $display("[TB] FAIL %s rsp_valid: got %b, expected %b (cycle %0d)", tag, obs_valid, m_valid(), cyc);
      end
      if (obs_valid === 1'b1) begin
        checks++;
        if (obs_inst !== fl_inst[got] || obs_err !== fl_err[got]) begin
          errors++; $display("[TB] FAIL %s response %0d: got inst=%h err=%b, expected inst=%h err=%b",
                             tag, got, obs_inst, obs_err, fl_inst[got], fl_err[got]);
        end
        got++;
      end
      if (req_valid && m_ready()) sent++;
      tick();
      budget++;
    end
    req_valid = 1'b0;
    checks++;
    if (got != fl_addr.size()) begin
      errors++; $display("[TB] FAIL %s timeout: got %0d responses, expected %0d", tag, got, fl_addr.size());
    end
    fl_addr.delete(); fl_inst.delete(); fl_err.delete();
  endtask

  task automatic test_back_to_back();
    fl_addr.push_back(64'h8000_0000); fl_inst.push_back(32'h0000_0093); fl_err.push_back(1'b0);
    fl_addr.push_back(64'h8000_0004); fl_inst.push_back(32'h0010_0113); fl_err.push_back(1'b0);
    fl_addr.push_back(64'h8000_0008); fl_inst.push_back(32'h0020_0193); fl_err.push_back(1'b0);
    fl_addr.push_back(64'h8000_000C); fl_inst.push_back(32'h0030_0213); fl_err.push_back(1'b0);
    test_fetch_list("back_to_back");
  endtask

  task automatic test_bad_addresses();
    fl_addr.push_back(64'h8000_0002);   fl_inst.push_back(32'h0); fl_err.push_back(1'b1);
    fl_addr.push_back(64'h7FFF_FFFC);   fl_inst.push_back(32'h0); fl_err.push_back(1'b1);
    fl_addr.push_back(64'h8000_1000);   fl_inst.push_back(32'h0); fl_err.push_back(1'b1);
    fl_addr.push_back(64'h8000_0FFC);   fl_inst.push_back(mem_m[DEPTH-1]); fl_err.push_back(1'b0);
    fl_addr.push_back(64'h1_8000_0000); fl_inst.push_back(32'h0); fl_err.push_back(1'b1);
    fl_addr.push_back(64'h0);           fl_inst.push_back(32'h0); fl_err.push_back(1'b1);
    test_fetch_list("bad_addr");
  endtask

  task automatic test_collision();
    bit seen;
    seen      = 1'b0;
    rsp_ready = 1'b1;
    ld_en     = 1'b1; ld_addr = BASE + 64'd20; ld_data = 32'hDEAD_BEEF;
    req_valid = 1'b1; req_addr = BASE + 64'd20;
    checks++;
    if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL collision req_ready: got %b, expected 1", obs_ready); end
    tick();
    ld_en = 1'b0; req_valid = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (obs_valid === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (obs_inst !== 32'h0000_0013 || obs_err !== 1'b0) begin
          errors++; $display("[TB] FAIL collision old data: got inst=%h err=%b, expected inst=00000013 err=0", obs_inst, obs_err);
        end
      end
      tick();
    end
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL collision timeout: no response, expected one"); end
    fl_addr.push_back(BASE + 64'd20); fl_inst.push_back(32'hDEAD_BEEF); fl_err.push_back(1'b0);
    test_fetch_list("collision_refetch");
  endtask

  task automatic test_backpressure();
    int sent, got, budget;
    sent = 0; got = 0; budget = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 9; c++) begin
      req_valid = (sent < 3);
      req_addr  = BASE + 64'(4 * sent);
      checks++;
      if (obs_ready !== m_ready()) begin
        errors++; $display("[TB] FAIL backpressure req_ready: got %b, expected %b (cycle %0d)", obs_ready, m_ready(), cyc);
      end
      checks++;
      if (obs_valid !== m_valid()) begin
        errors++; $display("[TB] FAIL backpressure rsp_valid: got %b, expected %b (cycle %0d)", obs_valid, m_valid(), cyc);
      end
      if (c >= 3) begin
        checks++;
        if (obs_ready !== 1'b0 || obs_valid !== 1'b1 || obs_inst !== mem_m[0] || obs_err !== 1'b0) begin
          errors++; $display("[TB] FAIL backpressure hold: got ready=%b valid=%b inst=%h, expected ready=0 valid=1 inst=%h",
                             obs_ready, obs_valid, obs_inst, mem_m[0]);
        end
      end
      if (req_valid && m_ready()) sent++;
      tick();
    end
    rsp_ready = 1'b1;
    while (got < 3 && budget < 20) begin
      req_valid = (sent < 3);
      req_addr  = BASE + 64'(4 * sent);
      checks++;
      if (obs_ready !== m_ready()) begin
        errors++; $display("[TB] FAIL drain req_ready: got %b, expected %b (cycle %0d)", obs_ready, m_ready(), cyc);
      end
      checks++;
      if (obs_valid !== m_valid()) begin
        errors++; $display("[TB] FAIL drain rsp_valid: got %b, expected %b (cycle %0d)", obs_valid, m_valid(), cyc);
      end
      if (obs_valid === 1'b1) begin
        checks++;
        if (obs_inst !== mem_m[got] || obs_err !== 1'b0) begin
          errors++; $display("[TB] FAIL drain response %0d: got inst=%h err=%b, expected inst=%h err=0", got, obs_inst, obs_err, mem_m[got]);
        end
        got++;
      end
      if (req_valid && m_ready()) sent++;
      tick();
      budget++;
    end
    req_valid = 1'b0;
    checks++;
    if (got != 3) begin errors++; $display("[TB] FAIL drain timeout: got %0d responses, expected 3", got); end
  endtask

  task automatic test_reset_midflight();
    int budget;
    budget    = 0;
    rsp_ready = 1'b0;
    while (q_inst.size() < 2 && budget < 10) begin
      req_valid = 1'b1;
      req_addr  = BASE + 64'(4 * q_inst.size());
      tick();
      budget++;
    end
    req_valid = 1'b0;
    checks++;
    if (obs_ready !== 1'b0 || obs_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset setup: got ready=%b valid=%b, expected ready=0 valid=1", obs_ready, obs_valid);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset async: got valid=%b ready=%b, expected valid=0 ready=1", obs_valid, obs_ready);
    end
    model_clear();
    tick();
    tick();
    rst       = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (obs_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL midreset stale response: got rsp_valid=%b, expected 0 (cycle %0d)", obs_valid, cyc);
      end
      tick();
    end
    fl_addr.push_back(BASE);        fl_inst.push_back(mem_m[0]); fl_err.push_back(1'b0);
    fl_addr.push_back(BASE + 64'd4); fl_inst.push_back(mem_m[1]); fl_err.push_back(1'b0);
    test_fetch_list("midreset_refetch");
  endtask

  task automatic test_latency3();
    use3 = 1'b1;
    lat  = 3;
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = BASE + 64'd8;
    checks++;
    if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL lat3 req_ready: got %b, expected 1", obs_ready); end
    tick();
    req_valid = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      checks++;
      if (obs_valid !== (k >= 3)) begin
        errors++; $display("[TB] FAIL lat3 rsp_valid %0d edges after accept: got %b, expected %b", k, obs_valid, (k >= 3));
      end
      if (k < 3) tick();
    end
    checks++;
    if (obs_inst !== mem_m[2] || obs_err !== 1'b0) begin
      errors++; $display("[TB] FAIL lat3 data: got inst=%h err=%b, expected inst=%h err=0", obs_inst, obs_err, mem_m[2]);
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (obs_valid !== 1'b0) begin errors++; $display("[TB] FAIL lat3 drain: got rsp_valid=%b, expected 0", obs_valid); end
  endtask

  task automatic test_random(input string tag, input int n);
    int sel;
    for (int c = 0; c < n + 10; c++) begin
      if (c < n) begin
        req_valid = ($urandom_range(0, 9) < 7);
        sel       = $urandom_range(0, 9);
        case (sel)
          7:       req_addr = BASE + 64'(4 * $urandom_range(0, 15)) + 64'($urandom_range(1, 3));
          8:       req_addr = BASE + 64'(4 * DEPTH) + 64'(4 * $urandom_range(0, 3));
          9:       req_addr = ($urandom_range(0, 1) == 0) ? BASE - 64'(4 * $urandom_range(1, 4))
                                                          : 64'h1_0000_0000 + BASE;
          default: req_addr = BASE + 64'(4 * $urandom_range(0, 15));
        endcase
        rsp_ready = ($urandom_range(0, 9) < 6);
        ld_en     = ($urandom_range(0, 9) == 0);
        ld_addr   = BASE + 64'(4 * $urandom_range(0, 15)) + (($urandom_range(0, 3) == 0) ? 64'd2 : 64'd0);
        ld_data   = $urandom;
      end else begin
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        ld_en     = 1'b0;
      end
      checks++;
      if (obs_ready !== m_ready()) begin
        errors++; $display("[TB] FAIL %s req_ready: got %b, expected %b (cycle %0d)", tag, obs_ready, m_ready(), cyc);
      end
      checks++;
      if (obs_valid !== m_valid()) begin
        errors++; $display("[TB] FAIL %s rsp_valid: got %b, expected %b (cycle %0d)", tag, obs_valid, m_valid(), cyc);
      end else if (m_valid()) begin
        checks++;
        if (obs_inst !== q_inst[0] || obs_err !== q_err[0]) begin
          errors++; $display("[TB] FAIL %s response: got inst=%h err=%b, expected inst=%h err=%b (cycle %0d)",
                             tag, obs_inst, obs_err, q_inst[0], q_err[0], cyc);
        end
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    $display("[TB] imem_responder bench start");
    test_reset();
    preload();
    test_back_to_back();
    test_bad_addresses();
    test_collision();
    test_backpressure();
    test_reset_midflight();
    test_random("random_lat1", 300);
    test_latency3();
    test_random("random_lat3", 300);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
